// File: rtl/apu_wave_pkg.sv
// Shared types and constants for the channel 3 wave RAM arbiter.
package apu_wave_pkg;

    localparam int         WAVE_BYTES    = 16;
    localparam int         WAVE_AW       = $clog2(WAVE_BYTES);
    localparam logic [7:0] WAVE_OPEN_BUS = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_D,
        ST_CPU_A,
        ST_CPU_D
    } wave_arb_state_t;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [WAVE_AW-1:0] addr;
        logic [7:0]         wdata;
    } cpu_req_t;

    // Each byte holds two samples, and the high nibble plays first.
    function automatic logic [3:0] wave_nibble(input logic [7:0] b, input logic lo);
        return lo ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/wave_req_slot.sv
// One-deep pending-request holder. If load and clear arrive in the same cycle, load wins,
// so a newer request overwrites the one already held.
module wave_req_slot #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/wave_ram_arbiter.sv
// Wave RAM arbiter shared by CPU accesses and channel 3 sample fetches.
// Define WAVE_CGB_ACCESS_EN to drop the DMG access window, so CPU accesses during playback always reach RAM.
module wave_ram_arbiter
    import apu_wave_pkg::*;
#(
    parameter int         WINDOW   = 1,
    parameter logic [7:0] OPEN_BUS = WAVE_OPEN_BUS
) (
    input  logic       cery_2mhz,
    input  logic       apu_reset,
    input  logic       ch3_active,
    input  logic       fetch_req,
    input  logic [4:0] sample_idx,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    output logic [3:0] ram_a,
    output logic       ram_re,
    output logic       ram_we,
    output logic [7:0] ram_d,
    input  logic [7:0] ram_q,
    output logic [3:0] wave_play_d
);

    localparam logic [3:0] WIN_LOAD = 4'(WINDOW);

    wave_arb_state_t r_state;
    logic [3:0]      r_byte_addr;
    logic [7:0]      r_byte_buf;
    logic            r_nib_lo;
    logic [3:0]      r_win_cnt;
    logic            r_active_d;
    logic [4:0]      r_idx;
    logic            r_cur_rd;
    logic            r_cur_blocked;

    cpu_req_t   w_cpu_in;
    cpu_req_t   w_cpu_pend;
    cpu_req_t   w_cpu_req;
    logic       w_cpu_pend_v;
    logic       w_fetch_pend_v;
    logic [4:0] w_fetch_pend_idx;
    logic       w_fall;
    logic       w_free;
    logic       w_cpu_busy;
    logic       w_cpu_accept;
    logic       w_fetch_any;
    logic       w_cpu_any;
    logic [4:0] w_fetch_idx;
    logic       w_start_fetch;
    logic       w_start_cpu;
    logic [3:0] w_byte_addr_eff;
    logic [3:0] w_cpu_addr_eff;
    logic       w_win_ok;

    assign w_cpu_in = '{rd: cpu_rd, wr: cpu_wr & ~cpu_rd, addr: cpu_addr, wdata: cpu_wdata};

    assign w_fall       = r_active_d & ~ch3_active;
    assign w_free       = (r_state == ST_IDLE) || (r_state == ST_FETCH_D) || (r_state == ST_CPU_D);
    assign w_cpu_busy   = (r_state == ST_CPU_A) || (r_state == ST_CPU_D);
    assign w_cpu_accept = (cpu_rd | cpu_wr) & ~w_cpu_busy & ~w_cpu_pend_v;

    // Incoming requests bypass their slots so a free FSM starts them without an extra cycle.
    assign w_fetch_any   = fetch_req | (w_fetch_pend_v & ~w_fall);
    assign w_fetch_idx   = fetch_req ? sample_idx : w_fetch_pend_idx;
    assign w_cpu_any     = w_cpu_pend_v | w_cpu_accept;
    assign w_cpu_req     = w_cpu_pend_v ? w_cpu_pend : w_cpu_in;
    assign w_start_fetch = w_free & w_fetch_any;
    assign w_start_cpu   = w_free & ~w_fetch_any & w_cpu_any;

    // Leaving FETCH_D, the byte address and window counter are about to take their fetch values.
    assign w_byte_addr_eff = (r_state == ST_FETCH_D) ? r_idx[4:1] : r_byte_addr;
    assign w_cpu_addr_eff  = ch3_active ? w_byte_addr_eff : w_cpu_req.addr;

`ifdef WAVE_CGB_ACCESS_EN
    assign w_win_ok = 1'b1;
`else
    assign w_win_ok = ~ch3_active |
                      ((r_state == ST_FETCH_D) ? (WIN_LOAD != 4'd0) : (r_win_cnt != 4'd0));
`endif

    wave_req_slot #(.W(5)) u_fetch_slot (
        .i_clk   (cery_2mhz),
        .i_rst   (apu_reset),
        .i_load  (fetch_req & ~w_start_fetch),
        .i_clear (w_start_fetch | w_fall),
        .i_data  (sample_idx),
        .o_valid (w_fetch_pend_v),
        .o_data  (w_fetch_pend_idx)
    );

    wave_req_slot #(.W($bits(cpu_req_t))) u_cpu_slot (
        .i_clk   (cery_2mhz),
        .i_rst   (apu_reset),
        .i_load  (w_cpu_accept & ~w_start_cpu),
        .i_clear (w_start_cpu),
        .i_data  (w_cpu_in),
        .o_valid (w_cpu_pend_v),
        .o_data  (w_cpu_pend)
    );

    always_ff @(posedge cery_2mhz or posedge apu_reset) begin
        if (apu_reset) begin
            r_state       <= ST_IDLE;
            r_byte_addr   <= '0;
            r_byte_buf    <= '0;
            r_nib_lo      <= 1'b0;
            r_win_cnt     <= '0;
            r_active_d    <= 1'b0;
            r_idx         <= '0;
            r_cur_rd      <= 1'b0;
            r_cur_blocked <= 1'b0;
            cpu_rdata     <= '0;
            cpu_rvalid    <= 1'b0;
            ram_a         <= '0;
            ram_re        <= 1'b0;
            ram_we        <= 1'b0;
            ram_d         <= '0;
        end else begin
            r_active_d <= ch3_active;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            cpu_rvalid <= 1'b0;

            if (w_fall)
                r_win_cnt <= '0;
            else if (r_state == ST_FETCH_D)
                r_win_cnt <= WIN_LOAD;
            else if (r_win_cnt != 4'd0)
                r_win_cnt <= r_win_cnt - 4'd1;

            unique case (r_state)
                ST_FETCH_A: r_state <= ST_FETCH_D;
                ST_FETCH_D: begin
                    r_byte_buf  <= ram_q;
                    r_byte_addr <= r_idx[4:1];
                    r_nib_lo    <= r_idx[0];
                end
                ST_CPU_A:   r_state <= ST_CPU_D;
                ST_CPU_D: begin
                    if (r_cur_rd) begin
                        cpu_rdata  <= r_cur_blocked ? OPEN_BUS : ram_q;
                        cpu_rvalid <= 1'b1;
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase

            if (w_start_fetch) begin
                r_state <= ST_FETCH_A;
                r_idx   <= w_fetch_idx;
                ram_a   <= w_fetch_idx[4:1];
                ram_re  <= 1'b1;
            end else if (w_start_cpu) begin
                r_state       <= ST_CPU_A;
                r_cur_rd      <= w_cpu_req.rd;
                r_cur_blocked <= ~w_win_ok;
                ram_a         <= w_cpu_addr_eff;
                ram_re        <= w_cpu_req.rd & w_win_ok;
                ram_we        <= w_cpu_req.wr & w_win_ok;
                if (w_cpu_req.wr & w_win_ok)
                    ram_d <= w_cpu_req.wdata;
            end else if (w_free) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign wave_play_d = wave_nibble(r_byte_buf, r_nib_lo);

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Scoreboard bench for wave_ram_arbiter with a behavioural 16x8 synchronous RAM.
module tb_wave_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ch3_active;
    logic       fetch_req;
    logic [4:0] sample_idx;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic [3:0] ram_a;
    logic       ram_re;
    logic       ram_we;
    logic [7:0] ram_d;
    logic [7:0] ram_q = 8'h00;
    logic [3:0] wave_play_d;

    always #5 clk = ~clk;

    wave_ram_arbiter dut (
        .cery_2mhz   (clk),
        .apu_reset   (rst),
        .ch3_active  (ch3_active),
        .fetch_req   (fetch_req),
        .sample_idx  (sample_idx),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .ram_a       (ram_a),
        .ram_re      (ram_re),
        .ram_we      (ram_we),
        .ram_d       (ram_d),
        .ram_q       (ram_q),
        .wave_play_d (wave_play_d)
    );

    // Synchronous RAM model; the bench preloads it through the poke port while the DUT is idle.
    logic [7:0] mem [16];
    logic       poke_en = 1'b0;
    logic [3:0] poke_a  = 4'd0;
    logic [7:0] poke_d  = 8'd0;

    always @(posedge clk) begin
        if (ram_re) ram_q <= mem[ram_a];
        if (ram_we) mem[ram_a] <= ram_d;
        else if (poke_en) mem[poke_a] <= poke_d;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [3:0] wave_q[$];
    int checks   = 0;
    int failures = 0;
    int re_count = 0;
    int we_count = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        tick(1);
        poke_en = 1'b0;
    endtask

    task automatic pulse(input logic f, input logic [4:0] idx, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        fetch_req  = f;
        sample_idx = idx;
        cpu_rd     = rd;
        cpu_wr     = wr;
        cpu_addr   = a;
        cpu_wdata  = d;
        tick(1);
        fetch_req  = 1'b0;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b0;
    endtask

    // Pops the read scoreboard whenever the DUT presents read data and watches the enable invariant.
    task automatic monitor();
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (ram_re) re_count++;
            if (ram_we) we_count++;
            if (ram_re || ram_we) begin
                checks++;
                if (ram_re && ram_we) begin
                    failures++;
                    $display("FAIL re_we_exclusive got re=%b we=%b want not both", ram_re, ram_we);
                end
            end
            if (cpu_rvalid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid got rdata=%h at cyc %0d want no rvalid", cpu_rdata, cyc);
                end else begin
                    e = rd_q.pop_front();
                    if (cpu_rdata !== e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL cpu_read got %h at cyc %0d want %h at cyc %0d",
                                 cpu_rdata, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (rd_q.size() == 0) break;
            tick(1);
        end
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL read_timeout got %0d outstanding want 0", rd_q.size());
            rd_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        got = {wave_play_d, cpu_rdata, cpu_rvalid, ram_re, ram_we, ram_a, ram_d};
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        checks++;
        if (ram_re !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_enables got re=%b we=%b want 0 0", ram_re, ram_we);
        end
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rvalid got %b want 0", cpu_rvalid);
        end
    endtask

    task automatic test_inactive_read();
        ch3_active = 1'b0;
        pulse(1'b0, 5'd0, 1'b1, 1'b0, 4'd3, 8'h00);
        rd_q.push_back('{data: 8'hA5, cyc: cyc + 2});
        checks++;
        if ({ram_re, ram_we, ram_a} !== {1'b1, 1'b0, 4'd3}) begin
            failures++;
            $display("FAIL inactive_read_cycle got re=%b we=%b a=%h want 1 0 3", ram_re, ram_we, ram_a);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        ch3_active = 1'b0;
        pulse(1'b0, 5'd0, 1'b1, 1'b0, 4'd4, 8'h00);
        rd_q.push_back('{data: 8'h96, cyc: cyc + 2});
        // Fetch arrives while the read executes; the simultaneous second read must be ignored.
        pulse(1'b1, 5'd8, 1'b1, 1'b0, 4'd0, 8'h00);
        wave_q.push_back(4'h9);
        tick(1);
        checks++;
        if ({ram_re, ram_a} !== {1'b1, 4'd4}) begin
            failures++;
            $display("FAIL pending_fetch_start got re=%b a=%h want 1 4", ram_re, ram_a);
        end
        tick(2);
        exp = wave_q.pop_front();
        checks++;
        if (wave_play_d !== exp) begin
            failures++;
            $display("FAIL pending_fetch_wave got %h want %h", wave_play_d, exp);
        end
        wait_drain();
    endtask

    task automatic test_fetch();
        logic [3:0] exp;
        ch3_active = 1'b1;
        pulse(1'b1, 5'd6, 1'b0, 1'b0, 4'd0, 8'h00);
        wave_q.push_back(4'hC);
        checks++;
        if ({ram_re, ram_a} !== {1'b1, 4'd3}) begin
            failures++;
            $display("FAIL fetch_cycle got re=%b a=%h want 1 3", ram_re, ram_a);
        end
        tick(2);
        exp = wave_q.pop_front();
        checks++;
        if (wave_play_d !== exp) begin
            failures++;
            $display("FAIL fetch_hi_nibble got %h want %h", wave_play_d, exp);
        end
        pulse(1'b1, 5'd7, 1'b0, 1'b0, 4'd0, 8'h00);
        wave_q.push_back(4'h4);
        tick(2);
        exp = wave_q.pop_front();
        checks++;
        if (wave_play_d !== exp) begin
            failures++;
            $display("FAIL fetch_lo_nibble got %h want %h", wave_play_d, exp);
        end
    endtask

    task automatic test_window_read();
        int re_before;
        logic       exp_re;
        logic [7:0] exp_q;
        int         exp_cnt;
        ch3_active = 1'b1;
        pulse(1'b1, 5'd6, 1'b0, 1'b0, 4'd0, 8'h00);
        tick(2);
        pulse(1'b0, 5'd0, 1'b1, 1'b0, 4'd9, 8'h00);
        rd_q.push_back('{data: 8'hC4, cyc: cyc + 2});
        checks++;
        if ({ram_re, ram_a} !== {1'b1, 4'd3}) begin
            failures++;
            $display("FAIL window_open_read got re=%b a=%h want 1 3", ram_re, ram_a);
        end
        wait_drain();

`ifdef WAVE_CGB_ACCESS_EN
        exp_re = 1'b1; exp_q = 8'hC4; exp_cnt = 1;
`else
        exp_re = 1'b0; exp_q = 8'hFF; exp_cnt = 0;
`endif
        pulse(1'b1, 5'd6, 1'b0, 1'b0, 4'd0, 8'h00);
        tick(6);
        re_before = re_count;
        pulse(1'b0, 5'd0, 1'b1, 1'b0, 4'd9, 8'h00);
        rd_q.push_back('{data: exp_q, cyc: cyc + 2});
        checks++;
        if (ram_re !== exp_re) begin
            failures++;
            $display("FAIL window_closed_re got %b want %b", ram_re, exp_re);
        end
        wait_drain();
        checks++;
        if (re_count - re_before != exp_cnt) begin
            failures++;
            $display("FAIL window_closed_re_count got %0d want %0d", re_count - re_before, exp_cnt);
        end
    endtask

    task automatic test_priority_write();
        logic [3:0] exp;
        ch3_active = 1'b0;
        tick(1);
        pulse(1'b1, 5'd10, 1'b0, 1'b1, 4'd2, 8'h5A);
        wave_q.push_back(4'h3);
        checks++;
        if ({ram_re, ram_we, ram_a} !== {1'b1, 1'b0, 4'd5}) begin
            failures++;
            $display("FAIL prio_fetch_first got re=%b we=%b a=%h want 1 0 5", ram_re, ram_we, ram_a);
        end
        tick(1);
        checks++;
        if ({ram_re, ram_we} !== 2'b00) begin
            failures++;
            $display("FAIL prio_fetch_data got re=%b we=%b want 0 0", ram_re, ram_we);
        end
        tick(1);
        checks++;
        if ({ram_we, ram_re, ram_a, ram_d} !== {1'b1, 1'b0, 4'd2, 8'h5A}) begin
            failures++;
            $display("FAIL prio_cpu_write got we=%b re=%b a=%h d=%h want 1 0 2 5a", ram_we, ram_re, ram_a, ram_d);
        end
        exp = wave_q.pop_front();
        checks++;
        if (wave_play_d !== exp) begin
            failures++;
            $display("FAIL prio_wave got %h want %h", wave_play_d, exp);
        end
        tick(1);
        checks++;
        if (mem[2] !== 8'h5A) begin
            failures++;
            $display("FAIL prio_ram_written got %h want 5a", mem[2]);
        end
    endtask

    task automatic test_window_write();
        int         we_before;
        int         exp_cnt;
        logic [7:0] exp_b5;
`ifdef WAVE_CGB_ACCESS_EN
        exp_cnt = 1; exp_b5 = 8'h77;
`else
        exp_cnt = 0; exp_b5 = 8'h3E;
`endif
        ch3_active = 1'b1;
        tick(3);
        we_before = we_count;
        pulse(1'b0, 5'd0, 1'b0, 1'b1, 4'd1, 8'h77);
        tick(3);
        checks++;
        if (we_count - we_before != exp_cnt) begin
            failures++;
            $display("FAIL window_write_we got %0d want %0d", we_count - we_before, exp_cnt);
        end
        checks++;
        if (mem[5] !== exp_b5 || mem[1] !== 8'h11) begin
            failures++;
            $display("FAIL window_write_ram got b5=%h b1=%h want %h 11", mem[5], mem[1], exp_b5);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] got;
        logic [3:0]  exp;
        ch3_active = 1'b1;
        pulse(1'b1, 5'd4, 1'b0, 1'b0, 4'd0, 8'h00);
        checks++;
        if (ram_re !== 1'b1) begin
            failures++;
            $display("FAIL mid_fetch_started got re=%b want 1", ram_re);
        end
        rst = 1'b1;
        #1;
        got = {wave_play_d, cpu_rdata, cpu_rvalid, ram_re, ram_we, ram_a, ram_d};
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_outputs got %h want 0", got);
        end
        tick(1);
        checks++;
        if ({ram_re, ram_we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_enables got re=%b we=%b want 0 0", ram_re, ram_we);
        end
        rst = 1'b0;
        tick(1);
        pulse(1'b1, 5'd1, 1'b0, 1'b0, 4'd0, 8'h00);
        wave_q.push_back(4'hB);
        checks++;
        if ({ram_re, ram_a} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL post_reset_fetch got re=%b a=%h want 1 0", ram_re, ram_a);
        end
        tick(2);
        exp = wave_q.pop_front();
        checks++;
        if (wave_play_d !== exp) begin
            failures++;
            $display("FAIL post_reset_wave got %h want %h", wave_play_d, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        ch3_active = 1'b0;
        fetch_req  = 1'b0;
        sample_idx = 5'd0;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b0;
        cpu_addr   = 4'd0;
        cpu_wdata  = 8'd0;
        fork
            monitor();
        join_none
        #2 rst = 1'b1;
        tick(2);
        test_reset();
        rst = 1'b0;
        tick(1);
        poke(4'd0, 8'h7B);
        poke(4'd1, 8'h11);
        poke(4'd2, 8'h00);
        poke(4'd3, 8'hA5);
        poke(4'd4, 8'h96);
        poke(4'd5, 8'h3E);
        test_inactive_read();
        test_back_to_back();
        poke(4'd3, 8'hC4);
        test_fetch();
        test_window_read();
        test_priority_write();
        test_window_write();
        test_reset_mid_fetch();
        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_ram_arbiter.md
Name: wave_ram_arbiter

Overview:
- Arbitrates the single-port 16x8 wave RAM between the CPU (FF30-FF3F) and channel 3 playback fetches.
- Sequences RAM read/write cycles and latches each fetched byte.
- Presents the selected 4-bit sample on wave_play_d for the channel 3 volume/DAC path.
- Implements the DMG quirk for CPU access while channel 3 is active: the access is redirected to the byte currently being played and succeeds only inside a short window after a fetch.

Parameters:
- WINDOW, 1, cycles after a completed fetch during which a CPU access while active reaches RAM.
- OPEN_BUS, 8'hFF, read data returned for a CPU read outside the window.

Ports:
- cery_2mhz  in  1  clock; all state updates on its rising edge.
- apu_reset  in  1  asynchronous, active-high reset.
- ch3_active  in  1  channel 3 playing.
- fetch_req  in  1  single-cycle pulse from the wave position counter on each sample advance.
- sample_idx  in  5  sample position 0-31, valid with fetch_req.
- cpu_rd  in  1  single-cycle CPU read strobe for FF30-FF3F.
- cpu_wr  in  1  single-cycle CPU write strobe for FF30-FF3F.
- cpu_addr  in  4  low address nibble.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- ram_a  out  4  wave RAM byte address.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_d  out  8  RAM write data.
- ram_q  in  8  RAM read data, valid the cycle after ram_re.
- wave_play_d  out  4  current sample nibble.

Behaviour:
- Reset (async): state IDLE, pending flags 0, byte_addr 0, byte_buf 0, window counter 0. Outputs: wave_play_d 0, cpu_rdata 0, cpu_rvalid 0, ram_re/ram_we 0, ram_a 0, ram_d 0.
- FSM states: IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D.
- FETCH_A: ram_a = idx[4:1], ram_re = 1.
- FETCH_D:
  - byte_buf <= ram_q; byte_addr <= idx[4:1].
  - wave_play_d <= idx[0] ? ram_q[3:0] : ram_q[7:4] (high nibble first).
  - Window counter loads WINDOW.
- Fetch latency: fetch_req at cycle n gives wave_play_d updated at n+2.
- CPU_A:
  - Read: ram_re = 1.
  - Write: ram_we = 1, ram_d = wdata.
  - ram_a = effective address.
- CPU_D: read gives cpu_rdata <= ram_q. cpu_rvalid pulses for reads only.
- CPU latency: strobe at n gives cpu_rvalid at n+2 when the FSM is idle at n.
- Effective address:
  - Inactive: cpu_addr.
  - Active: byte_addr, cpu_addr ignored.
- Window rule while active:
  - Counter > 0 at the strobe cycle: the access proceeds normally.
  - Counter = 0, read: no RAM cycle; cpu_rdata = OPEN_BUS and cpu_rvalid still pulse at n+2.
  - Counter = 0, write: dropped, no ram_we.
- Window counter decrements each cycle in states other than FETCH_D, saturating at 0.
- Priority: fetch over CPU.
  - Simultaneous fetch_req and CPU strobe: fetch runs first; the CPU request is held pending (one-deep, latching addr, data and rd/wr) and runs immediately after FETCH_D.
  - The window test for a pending CPU request uses the counter value when it enters CPU_A.
- Requests arriving while busy:
  - fetch_req while busy: sets pending fetch (one-deep), serviced before any later CPU request. A second fetch_req while a fetch is already pending overwrites idx.
  - CPU strobe while a CPU request is already pending or executing: ignored, with no rvalid.
- ch3_active falling edge: window counter cleared and pending fetch dropped; any in-flight cycle completes. wave_play_d holds its value.
- Reset mid-cycle: abort immediately; no further RAM enables.
- Invariant: ram_re and ram_we are never high together.

Optional Feature:
- Macro: WAVE_CGB_ACCESS_EN.
- Defined: window rule disabled. While active, every CPU access reaches byte_addr: reads return RAM data and writes land.
- Undefined: DMG window rule as above.

Decomposition:
- Shared package apu_wave_pkg:
  - wave_arb_state_t enum.
  - WAVE_BYTES = 16.
  - WAVE_OPEN_BUS = 8'hFF.
  - cpu_req_t struct {rd, wr, addr[3:0], wdata[7:0]}.
- One natural sub-module, wave_req_slot: a one-deep pending-request holder with load, clear and valid, instanced for fetch and CPU.

Test Plan:
- Inactive, RAM byte 3 = 8'hA5; cpu_rd addr 3 at n -> ram_re with ram_a = 3 at n, cpu_rdata = 8'hA5 and cpu_rvalid at n+2.
- Active, fetch_req idx 6 at n, RAM byte 3 = 8'hC4 -> wave_play_d = 4'hC at n+2; idx 7 then gives 4'h4.
- Active, fetch completes, cpu_rd addr 9 one cycle later -> reads byte 3. The same read 5 cycles later -> cpu_rdata = 8'hFF and no ram_re. With WAVE_CGB_ACCESS_EN defined -> byte 3 data.
- fetch_req and cpu_wr addr 2, data 8'h5A in the same cycle, inactive -> fetch cycle first, then ram_we with ram_a = 2 and ram_d = 8'h5A.
- Active, cpu_wr outside the window -> no ram_we, RAM unchanged.
- apu_reset pulsed mid FETCH_A -> all outputs 0 asynchronously; the next fetch_req behaves as from reset.
